// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags,
// registered read data with valid pulse, and sticky overflow/underflow.
module sync_fifo_param #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AFULL_TH  = DEPTH - 2,
  parameter int unsigned AEMPTY_TH = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           dataIn,
  input  logic                        writeEn,
  input  logic                        readEn,
  input  logic                        clearErr,
  output logic [DATA_W-1:0]           dataOut,
  output logic                        dataValid,
  output logic                        Full,
  output logic                        Empty,
  output logic                        almostFull,
  output logic                        almostEmpty,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [AW-1:0]     wp_q, wp_d;
  logic [AW-1:0]     rp_q, rp_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dvalid_q, dvalid_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              full_c, empty_c;
  logic              rd_acc, wr_acc;

  // Status decodes straight off the registered count
  always_comb begin
    full_c      = (count_q == CW'(DEPTH));
    empty_c     = (count_q == '0);
    almostFull  = (count_q >= CW'(AFULL_TH));
    almostEmpty = (count_q <= CW'(AEMPTY_TH));
  end

  assign Full  = full_c;
  assign Empty = empty_c;

  // Accept logic: a write into a full FIFO only lands when a read frees a slot
  always_comb begin
    rd_acc = readEn & ~empty_c;
    wr_acc = writeEn & (~full_c | rd_acc);
  end

  // Next-state for pointers, count, read data and sticky error flags
  always_comb begin
    wp_d     = wp_q;
    rp_d     = rp_q;
    count_d  = count_q;
    dout_d   = dout_q;
    dvalid_d = 1'b0;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    if (wr_acc) wp_d = wp_q + AW'(1);
    if (rd_acc) begin
      rp_d     = rp_q + AW'(1);
      dout_d   = mem_q[rp_q];
      dvalid_d = 1'b1;
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Set beats clear when both happen in the same cycle
    if (clearErr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (writeEn & ~wr_acc) ovf_d = 1'b1;
    if (readEn & ~rd_acc)  unf_d = 1'b1;
  end

  // Control and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      wp_q     <= '0;
      rp_q     <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage array, intentionally not reset; writes suppressed while in reset
  always_ff @(posedge clk) begin
    if (reset && wr_acc) mem_q[wp_q] <= dataIn;
  end

  assign dataOut   = dout_q;
  assign dataValid = dvalid_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule
